div_unit: RTL and testbench

Iterative 32-bit integer divider implementing the RISC-V M-extension DIV, DIVU, REM and REMU operations. It is the division counterpart to the single-cycle multiply in the ALU. It sits in the EX stage beside the ALU and takes operands from the same forwarding muxes. The hazard unit stalls IF/ID/EX while `busy_o` is high; the result is written to EX/MEM on the `valid_o` cycle.

---
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV, DIVU, REM and REMU.
// One quotient bit per cycle, MSB first; fixed latency of WIDTH cycles from
// the accepting edge to the valid_o pulse, including the divide-by-zero and
// signed-overflow cases, which are patched in at DONE entry.
//
// state | meaning
// IDLE  | waiting for start_i; operands are latched on the accepting edge
// RUN   | one restoring-division iteration per cycle, counter 0..WIDTH-1
// DONE  | data_o holds the result; valid_o pulses, then back to IDLE
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       DivCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               last;
  logic [2*WIDTH-1:0] rq, rq_nxt, shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   divisor, dividend_raw;
  logic [1:0]         op;
  logic               neg_q, neg_r, div_zero, ovf;

  logic               is_signed_in, sign1, sign2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   q_raw, r_raw, q_fin, r_fin, result;

  assign last = (cnt == CW'(WIDTH - 1));

  // Operand preparation: signed ops divide magnitudes and fix signs at the end.
  always_comb begin
    is_signed_in = ~DivCtrl_i[0];
    sign1        = is_signed_in & data1_i[WIDTH-1];
    sign2        = is_signed_in & data2_i[WIDTH-1];
    abs1         = sign1 ? -data1_i : data1_i;
    abs2         = sign2 ? -data2_i : data2_i;
  end

  // One restoring iteration: shift, trial-subtract, keep difference on no borrow.
  always_comb begin
    shifted = {rq[2*WIDTH-2:0], 1'b0};
    diff    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    if (diff[WIDTH]) rq_nxt = shifted;
    else             rq_nxt = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
  end

  // Final result from the last iteration, with sign fix-up and special cases.
  always_comb begin
    q_raw = rq_nxt[WIDTH-1:0];
    r_raw = rq_nxt[2*WIDTH-1:WIDTH];
    if (div_zero) begin
      q_fin = '1;
      r_fin = dividend_raw;
    end else if (ovf) begin
      q_fin = MIN_NEG;
      r_fin = '0;
    end else begin
      q_fin = neg_q ? -q_raw : q_raw;
      r_fin = neg_r ? -r_raw : r_raw;
    end
    result = op[1] ? r_fin : q_fin;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start_i only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (last)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state flops.
  always_comb begin
    busy_o  = (state != IDLE);
    valid_o = (state == DONE);
  end

  // Datapath: operand latch on accept, iterate in RUN, load data_o on the last step.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt          <= '0;
      rq           <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      op           <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      ovf          <= 1'b0;
      data_o       <= '0;
    end else if (state == IDLE) begin
      if (start_i) begin
        cnt          <= '0;
        rq           <= {{WIDTH{1'b0}}, abs1};
        divisor      <= abs2;
        dividend_raw <= data1_i;
        op           <= DivCtrl_i;
        neg_q        <= sign1 ^ sign2;
        neg_r        <= sign1;
        div_zero     <= (data2_i == '0);
        ovf          <= is_signed_in && (data1_i == MIN_NEG) && (data2_i == '1);
      end
    end else if (state == RUN) begin
      rq  <= rq_nxt;
      cnt <= cnt + 1'b1;
      if (last) data_o <= result;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes the expected result and
// the cycle it must appear on; an independent monitor pops on every valid_o.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  DivCtrl_i = 2'b00;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [31:0] data_o;
  logic        valid_o;
  logic        busy_o;

  div_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .DivCtrl_i(DivCtrl_i),
    .data1_i(data1_i), .data2_i(data2_i),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: RISC-V M-extension semantics written as plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    logic [31:0] q, r;
    sa  = a;
    sbv = b;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (op[0] == 1'b0) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        q = 32'h80000000;
        r = 32'd0;
      end else begin
        q = sa / sbv;
        r = sa % sbv;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Monitor: every valid_o must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i && valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=valid required=no_valid data=%h", data_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, data_o, e.data);
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        chk({e.name, "_busy_in_done"}, {31'd0, busy_o}, 32'd1);
      end
    end
  end

  // Issue one operation; returns right after the accepting edge E0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string name);
    exp_t e;
    @(negedge clk_i);
    start_i   = 1'b1;
    DivCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    @(posedge clk_i);
    #1;
    start_i   = 1'b0;
    data1_i   = $urandom;
    data2_i   = $urandom;
    DivCtrl_i = 2'($urandom_range(0, 3));
    e.data = ref_model(op, a, b);
    e.due  = cyc + 32;
    e.name = name;
    sb.push_back(e);
  endtask

  // Wait until the scoreboard drains (returns just after E33), then check release.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_valid required=valid", name);
      sb.delete();
    end else begin
      chk({name, "_busy_after"}, {31'd0, busy_o}, 32'd0);
      chk({name, "_valid_after"}, {31'd0, valid_o}, 32'd0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    int s;
    s = $urandom_range(0, 11);
    case (s)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'(($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [1:0] op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_data", data_o, 32'd0);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    issue(2'b00, 32'hFFFFFFF9, 32'd2, "div_m7_2");        wait_done("div_m7_2");
    issue(2'b10, 32'hFFFFFFF9, 32'd2, "rem_m7_2");        wait_done("rem_m7_2");
    issue(2'b10, 32'd7, 32'hFFFFFFFE, "rem_7_m2");        wait_done("rem_7_m2");
    issue(2'b01, 32'hFFFFFFFE, 32'd2, "divu_big_2");      wait_done("divu_big_2");
    issue(2'b11, 32'hFFFFFFFF, 32'd10, "remu_big_10");    wait_done("remu_big_10");
    issue(2'b00, 32'd123, 32'd0, "div_by_zero");          wait_done("div_by_zero");
    issue(2'b11, 32'h80000001, 32'd0, "remu_by_zero");    wait_done("remu_by_zero");
    issue(2'b00, 32'h80000000, 32'hFFFFFFFF, "div_ovf");  wait_done("div_ovf");
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");  wait_done("rem_ovf");

    // Handshake: starts during RUN and during DONE must be ignored.
    issue(2'b01, 32'd1000, 32'd7, "hs_main");
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1; DivCtrl_i = 2'b00; data1_i = 32'd55; data2_i = 32'd5;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    n = 0;
    while (!valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    start_i = 1'b1; DivCtrl_i = 2'b01; data1_i = 32'd99; data2_i = 32'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("hs_busy_fall_e33", {31'd0, busy_o}, 32'd0);
    chk("hs_main_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    issue(2'b00, 32'd200, 32'hFFFFFFF6, "hs_next");       wait_done("hs_next");
    issue(2'b11, 32'd200, 32'd7, "hs_b2b");               wait_done("hs_b2b");

    // Reset at iteration 10: everything clears at once, no valid afterwards.
    issue(2'b00, 32'd5000, 32'd3, "rst_victim");
    repeat (10) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_mid_data", data_o, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (40) @(posedge clk_i);
    issue(2'b00, 32'd100, 32'd7, "div_100_7");            wait_done("div_100_7");

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, "rand");
      wait_done("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
